// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state type, completion record type and base address for the DMA scheduler
package dma_pkg;
  localparam int ID_W_MAX = 3;
  localparam logic [31:0] DMA_BASE_ADDR = 32'h1002_0100;
  typedef enum logic [1:0] {IDLE, GRANT, RUN, CMPL} sched_state_t;
  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic                err;
  } cmpl_rec_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]     gnt_idx,
  output logic               any
);
  logic [IDW-1:0] w_j;
  always_comb begin
    gnt_idx = '0;
    w_j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[w_j]) gnt_idx = w_j;
    end
  end
  assign any = |req;
  assign gnt_onehot = any ? NUM_REQ'(1) << gnt_idx : '0;
endmodule

// File: rtl/dma_sched.sv
// dma_sched: round-robin scheduler sharing one DMA engine among NUM_REQ descriptor-chain requesters
module dma_sched
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 32,
  parameter int TO_W = 16,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_desc,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dma_en,
  output logic [ADDR_W-1:0]         dma_desc_base,
  input  logic                      dma_done,
  output logic [IDW-1:0]            grant_id,
  input  logic [TO_W-1:0]           to_limit,
  output logic                      cmpl_valid,
  output logic [IDW-1:0]            cmpl_id,
  output logic                      cmpl_err,
  input  logic                      cmpl_ready,
  output logic [NUM_REQ-1:0]        irq_pend,
  input  logic [NUM_REQ-1:0]        irq_clr,
  output logic                      dma_irq
);
  sched_state_t r_state, w_nxt;
  logic [NUM_REQ-1:0] r_pend, r_irq, w_hs, w_oh;
  logic [ADDR_W-1:0] r_desc [NUM_REQ];
  logic [ADDR_W-1:0] r_base;
  logic [IDW-1:0] r_ptr, r_gid, r_cid, w_idx;
  logic [TO_W-1:0] r_wd;
  logic r_en, r_cv, r_cerr, r_dirq, w_any, w_to, w_acc;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(r_pend),
    .ptr(r_ptr),
    .gnt_onehot(w_oh),
    .gnt_idx(w_idx),
    .any(w_any)
  );
  assign req_ready = rst ? '0 : ~r_pend;
  assign w_hs = req_valid & req_ready;
  assign w_to = (to_limit != '0) && (r_wd == to_limit - 1'b1);
  assign w_acc = (r_state == CMPL) && cmpl_ready;
  assign dma_en = r_en;
  assign dma_desc_base = r_base;
  assign grant_id = r_gid;
  assign cmpl_valid = r_cv;
  assign cmpl_id = r_cid;
  assign cmpl_err = r_cerr;
  assign irq_pend = r_irq;
  assign dma_irq = r_dirq;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = (w_any || |w_hs) ? GRANT : IDLE;
      GRANT:   w_nxt = RUN;
      RUN:     w_nxt = (dma_done || w_to) ? CMPL : RUN;
      CMPL:    w_nxt = cmpl_ready ? IDLE : CMPL;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_ptr <= '0;
      r_gid <= '0;
      r_base <= '0;
      r_wd <= '0;
      r_en <= 1'b0;
      r_cv <= 1'b0;
      r_cid <= '0;
      r_cerr <= 1'b0;
      r_irq <= '0;
      r_dirq <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_pend <= (r_pend | w_hs) & ~((r_state == GRANT) ? w_oh : '0);
      r_irq <= (r_irq & ~irq_clr) | (w_acc ? NUM_REQ'(1) << r_gid : '0);
      r_dirq <= |r_irq;
      if (r_state == GRANT && w_any) begin
        r_gid <= w_idx;
        r_base <= r_desc[w_idx];
        r_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        r_wd <= '0;
        r_en <= 1'b1;
      end
      if (r_state == RUN) begin
        r_wd <= &r_wd ? r_wd : r_wd + 1'b1;
        if (dma_done || w_to) begin
          r_en <= 1'b0;
          r_cv <= 1'b1;
          r_cid <= r_gid;
          r_cerr <= !dma_done;
        end
      end
      if (w_acc) r_cv <= 1'b0;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (w_hs[i]) r_desc[i] <= req_desc[i*ADDR_W +: ADDR_W];
endmodule

// File: tb/tb_dma_sched.sv
// tb_dma_sched: scoreboard bench for dma_sched grants, completions, watchdog, irq and reset
module tb_dma_sched;
  import dma_pkg::*;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int TW = 16;
  typedef struct {
    logic [1:0]  id;
    logic [31:0] desc;
  } g_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid, req_ready, irq_pend, irq_clr;
  logic [N*AW-1:0] req_desc;
  logic dma_en, dma_done, cmpl_valid, cmpl_err, cmpl_ready, dma_irq;
  logic [AW-1:0] dma_desc_base;
  logic [1:0] grant_id, cmpl_id;
  logic [TW-1:0] to_limit;
  g_t exp_g[$];
  cmpl_rec_t exp_c[$];
  g_t m_g;
  cmpl_rec_t m_c;
  int n_tests = 0, n_fail = 0;
  int low_run = 100, high_run = 0, last_high = 0;
  logic prev_en = 1'b0;
  always #5 clk = ~clk;
  dma_sched #(.NUM_REQ(N), .ADDR_W(AW), .TO_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_desc(req_desc),
    .req_ready(req_ready),
    .dma_en(dma_en),
    .dma_desc_base(dma_desc_base),
    .dma_done(dma_done),
    .grant_id(grant_id),
    .to_limit(to_limit),
    .cmpl_valid(cmpl_valid),
    .cmpl_id(cmpl_id),
    .cmpl_err(cmpl_err),
    .cmpl_ready(cmpl_ready),
    .irq_pend(irq_pend),
    .irq_clr(irq_clr),
    .dma_irq(dma_irq)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (dma_en && !prev_en) begin
      chk("en_gap", low_run >= 2, 1);
      chk("grant_q", exp_g.size() > 0, 1);
      if (exp_g.size() > 0) begin
        m_g = exp_g.pop_front();
        chk("grant_id", grant_id, m_g.id);
        chk("desc_base", dma_desc_base, m_g.desc);
      end
    end
    if (dma_en) begin
      high_run++;
      low_run = 0;
    end else begin
      if (prev_en) last_high = high_run;
      high_run = 0;
      low_run++;
    end
    prev_en = dma_en;
    if (cmpl_valid && cmpl_ready) begin
      chk("cmpl_q", exp_c.size() > 0, 1);
      if (exp_c.size() > 0) begin
        m_c = exp_c.pop_front();
        chk("cmpl_id", cmpl_id, m_c.id[1:0]);
        chk("cmpl_err", cmpl_err, m_c.err);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic post(input int i, input logic [31:0] a);
    chk("post_ready", req_ready[i], 1);
    req_valid[i] = 1'b1;
    req_desc[i*AW +: AW] = a;
    exp_g.push_back('{id: 2'(i), desc: a});
    tick();
    req_valid[i] = 1'b0;
  endtask
  task automatic pulse_done();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
  endtask
  task automatic wait_en(input logic lvl);
    int n = 0;
    while (dma_en !== lvl && n < 50) begin
      tick();
      n++;
    end
    chk("wait_en", dma_en, lvl);
  endtask
  task automatic clr_irq();
    irq_clr = '1;
    tick();
    irq_clr = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    req_valid = '0;
    req_desc = '0;
    dma_done = 1'b0;
    to_limit = 16'd100;
    cmpl_ready = 1'b1;
    irq_clr = '0;
    tick(2);
    chk("rst_outs", {dma_en, cmpl_valid, cmpl_err, dma_irq, irq_pend, grant_id, cmpl_id}, 0);
    chk("rst_base", dma_desc_base, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", req_ready, 4'hf);
    exp_g.push_back('{id: 2'd0, desc: 32'h1000});
    req_valid[0] = 1'b1;
    req_desc[31:0] = 32'h1000;
    tick();
    req_valid = '0;
    chk("t1_en_grant", dma_en, 0);
    tick();
    chk("t1_en_run", dma_en, 1);
    chk("t1_base", dma_desc_base, 32'h1000);
    tick(19);
    exp_c.push_back('{id: 3'd0, err: 1'b0});
    pulse_done();
    chk("t1_cv", cmpl_valid, 1);
    tick();
    chk("t1_irq", irq_pend, 4'b0001);
    chk("t1_dirq_lag", dma_irq, 0);
    tick();
    chk("t1_dirq", dma_irq, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_desc[i*AW +: AW] = 32'h2000 + 32'(i) * 32'h100;
      exp_g.push_back('{id: 2'(i), desc: 32'h2000 + 32'(i) * 32'h100});
    end
    req_valid = 4'hf;
    tick();
    req_valid = '0;
    tick();
    post(0, 32'h3000);
    for (int k = 0; k < 5; k++) begin
      wait_en(1'b1);
      tick(5);
      exp_c.push_back('{id: 3'(k % 4), err: 1'b0});
      pulse_done();
    end
    tick();
    chk("t2_irq", irq_pend, 4'hf);
    clr_irq();
    chk("t2_irq_clr", irq_pend, 0);
    to_limit = 16'd5;
    exp_c.push_back('{id: 3'd1, err: 1'b1});
    post(1, 32'h4000);
    wait_en(1'b1);
    wait_en(1'b0);
    tick();
    chk("t3_wd_len", last_high, 5);
    to_limit = 16'd0;
    post(2, 32'h5000);
    wait_en(1'b1);
    n = 0;
    repeat (1000) begin
      if (dma_en) n++;
      tick();
    end
    chk("t3_no_timeout", n, 1000);
    exp_c.push_back('{id: 3'd2, err: 1'b0});
    pulse_done();
    tick(2);
    clr_irq();
    to_limit = 16'd100;
    cmpl_ready = 1'b0;
    post(0, 32'h6000);
    wait_en(1'b1);
    post(2, 32'h7000);
    tick(3);
    exp_c.push_back('{id: 3'd0, err: 1'b0});
    pulse_done();
    n = 0;
    repeat (10) begin
      if (cmpl_valid && cmpl_id == 2'd0 && !cmpl_err && !dma_en && grant_id == 2'd0) n++;
      tick();
    end
    chk("t4_hold", n, 10);
    cmpl_ready = 1'b1;
    tick();
    chk("t4_cv_drop", cmpl_valid, 0);
    chk("t4_en_x1", dma_en, 0);
    tick();
    chk("t4_en_x2", dma_en, 0);
    chk("t4_gid_x2", grant_id, 0);
    tick();
    chk("t4_en_x3", dma_en, 1);
    chk("t4_gid_x3", grant_id, 2);
    exp_c.push_back('{id: 3'd2, err: 1'b0});
    pulse_done();
    tick(2);
    clr_irq();
    post(1, 32'h8000);
    wait_en(1'b1);
    exp_c.push_back('{id: 3'd1, err: 1'b0});
    pulse_done();
    irq_clr = 4'b0010;
    tick();
    irq_clr = '0;
    chk("t5_set_wins", irq_pend[1], 1);
    tick();
    chk("t5_dirq", dma_irq, 1);
    irq_clr = 4'b0010;
    tick();
    irq_clr = '0;
    chk("t5_clr", irq_pend, 0);
    chk("t5_dirq_hold", dma_irq, 1);
    tick();
    chk("t5_dirq_fall", dma_irq, 0);
    post(3, DMA_BASE_ADDR);
    wait_en(1'b1);
    req_desc[31:0] = 32'hA000;
    req_desc[63:32] = 32'hB000;
    req_valid = 4'b0011;
    tick();
    req_valid = '0;
    tick(2);
    rst = 1'b1;
    #1;
    chk("t6_ready_in_rst", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_outs", {dma_en, cmpl_valid, cmpl_err, dma_irq, irq_pend, grant_id, cmpl_id}, 0);
    chk("t6_base", dma_desc_base, 0);
    chk("t6_ready", req_ready, 4'hf);
    pulse_done();
    n = 0;
    repeat (6) begin
      if (!cmpl_valid && !dma_en) n++;
      tick();
    end
    chk("t6_no_cmpl", n, 6);
    chk("gq_empty", exp_g.size(), 0);
    chk("cq_empty", exp_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_sched.md
# dma_sched

Round-robin scheduler that shares the single DMA engine among NUM_REQ descriptor-chain requesters, for example the CPU CSR path and accelerators. Each requester posts a descriptor-chain base address into a one-entry pending slot. The scheduler grants one slot at a time, drives the engine's enable and descriptor base, and waits for chain completion or a watchdog timeout. It then posts a completion record and a sticky per-requester interrupt. It sits between the AXI slave CSR logic and the DMA core inside the DMA wrapper.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, descriptor address width
- TO_W, 16, watchdog counter width
- clk  in  1  clock
- rst  in  1  reset; one clock; synchronous, active-high
- req_valid  in  NUM_REQ  requester i posts a chain
- req_desc  in  NUM_REQ*ADDR_W  chain base address; slice i is [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  slot i is empty; reset 0
- dma_en  out  1  engine enable, held for the whole chain; reset 0
- dma_desc_base  out  ADDR_W  base address of the granted chain; reset 0
- dma_done  in  1  one-cycle pulse at the end of the EOC chain
- grant_id  out  $clog2(NUM_REQ)  current or last grant; reset 0
- to_limit  in  TO_W  watchdog limit in cycles; 0 disables the watchdog
- cmpl_valid  out  1  completion record valid; reset 0
- cmpl_id  out  $clog2(NUM_REQ)  requester of the record; reset 0
- cmpl_err  out  1  1 = record is a timeout abort; reset 0
- cmpl_ready  in  1  consumer accepts the record
- irq_pend  out  NUM_REQ  sticky per-requester interrupt; reset 0
- irq_clr  in  NUM_REQ  write-1-to-clear for irq_pend
- dma_irq  out  1  OR of irq_pend; reset 0

## Operation
- Pending slots:
  - req_ready[i] = ~pend[i] after reset. All slots read 0 during reset.
  - A handshake (valid & ready) latches req_desc slice i and sets pend[i].
  - pend[i] clears when slot i's grant is issued, not when its chain completes.
- FSM states: IDLE, GRANT, RUN, CMPL.
- IDLE to GRANT when any pend bit is set.
- GRANT (1 cycle):
  - Pick the first set pend bit, searching from rr_ptr upward with wrap.
  - Register grant_id and dma_desc_base.
  - Clear that pend bit.
  - Set rr_ptr = grant + 1, mod NUM_REQ.
  - Load wd_cnt = 0.
  - Go to RUN.
- RUN:
  - dma_en = 1.
  - wd_cnt increments every cycle and saturates at all ones.
  - dma_done: record err = 0, go to CMPL.
  - Otherwise, if to_limit != 0 and wd_cnt == to_limit-1: record err = 1, go to CMPL.
  - If dma_done and the timeout fire in the same cycle, dma_done wins and err = 0.
- CMPL:
  - dma_en = 0 from the first CMPL cycle. This drop is the engine's abort or disarm.
  - cmpl_valid = 1, with cmpl_id = grant_id and cmpl_err as recorded.
  - Hold until cmpl_ready. On acceptance, set irq_pend[grant_id] and return to IDLE.
- irq_pend:
  - In the same cycle, set wins over irq_clr for the same bit.
  - dma_irq is registered and equals the OR of irq_pend.
- A requester may repost in the cycle after its grant, because its slot is already free. This allows two chains per requester in flight in the scheduler: one running, one pending.
- Reset mid-chain: all state returns to reset values in the next cycle. dma_en drops and pending posts are lost; requesters must repost.

## Timing
- Post to dma_en, with the scheduler idle: handshake at cycle t, GRANT at t+1, dma_en = 1 from t+2.
- dma_done at cycle t: cmpl_valid = 1 from t+1.
- Accept at cycle t: irq_pend set at t+1, dma_irq at t+2, and the next GRANT no earlier than t+2.
- dma_en low gap between consecutive chains: at least 2 cycles (CMPL plus GRANT). The DMA core needs this to re-arm.
- Watchdog fires after exactly to_limit RUN cycles.
- dma_done outside RUN is ignored.
- All outputs are registered except req_ready, which is a combinational decode of pend.

## Structure
- Shared package dma_pkg:
  - typedef sched_state_t for the FSM.
  - Constant DMA_BASE_ADDR = 32'h1002_0100.
  - Typedef cmpl_rec_t {id, err}.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs gnt_onehot, gnt_idx and any. Purely combinational, reusable by the AXI bus.
- Everything else is flat in dma_sched: 120–250 lines.

## Test plan
- Single post: req0 posts 0x0000_1000 with to_limit = 100. dma_desc_base = 0x1000 and dma_en rises 2 cycles after the handshake. Pulse dma_done after 20 cycles. cmpl {id 0, err 0}, then irq_pend = 4'b0001.
- Fairness: all 4 requesters post in the same cycle, with rr_ptr = 0 after reset. Grant order is 0,1,2,3. Req0 reposts immediately, which makes the order 0,1,2,3,0. Check a dma_en low gap of at least 2 between every chain.
- Watchdog: to_limit = 5 and dma_done is never pulsed. dma_en is high for exactly 5 cycles, then cmpl_err = 1 with the correct id. to_limit = 0 never times out over 1000 cycles.
- Completion backpressure: hold cmpl_ready = 0 for 10 cycles with req2 pending. cmpl_valid and the record stay stable. No new grant occurs until 1 cycle after acceptance.
- irq: irq_clr[1] in the same cycle as the set of bit 1 leaves the bit set. A later irq_clr clears it, and dma_irq falls 1 cycle after.
- Reset in RUN: assert rst for 1 cycle during a chain with 2 posts pending. All outputs return to reset values, req_ready reads all ones afterward, and a stale dma_done produces no completion.
